// File: rtl/tbird_pkg.sv
// tbird_pkg: shared state type and lamp helpers for the Thunderbird sequencer family.
package tbird_pkg;

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} tbird_state_t;

    function automatic logic [31:0] thermo(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/tbird_seq_ctrl_if.sv
// tbird_seq_ctrl_if: switch inputs and lamp outputs; brake exists only with TBIRD_BRAKE_EN.
interface tbird_seq_ctrl_if #(parameter int LAMPS = 3);

    logic left;
    logic right;
    logic hazard;
`ifdef TBIRD_BRAKE_EN
    logic brake;
`endif
    logic [LAMPS-1:0] l_lamps;
    logic [LAMPS-1:0] r_lamps;
    logic step;

`ifdef TBIRD_BRAKE_EN
    modport master (output left, right, hazard, brake, input l_lamps, r_lamps, step);
    modport slave (input left, right, hazard, brake, output l_lamps, r_lamps, step);
`else
    modport master (output left, right, hazard, input l_lamps, r_lamps, step);
    modport slave (input left, right, hazard, output l_lamps, r_lamps, step);
`endif

endinterface

// File: rtl/tbird_prescaler.sv
// tbird_prescaler: one-cycle step strobe every DIV clocks, counting from reset release.
module tbird_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic step
);

    localparam int W = DIV > 1 ? $clog2(DIV) : 1;

    logic [W-1:0] tick_cnt;
    logic at_end;

    assign at_end = tick_cnt == W'(DIV - 1);
    // Gated so the strobe stays low while reset is held, even with DIV=1.
    assign step = reset && at_end;

    always_ff @(posedge clk) begin
        if (!reset) tick_cnt <= '0;
        else tick_cnt <= at_end ? '0 : tick_cnt + W'(1);
    end

endmodule

// File: rtl/tbird_seq_ctrl.sv
// tbird_seq_ctrl: parametrised turn/hazard lamp sequencer; optional brake override via TBIRD_BRAKE_EN.
module tbird_seq_ctrl
    import tbird_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1
) (
    input logic clk,
    input logic reset,
    tbird_seq_ctrl_if.slave bus
);

    localparam int SW = $clog2(LAMPS + 1);

    tbird_state_t state, state_n;
    logic [SW-1:0] step_cnt, step_cnt_n;
    logic hz_phase, hz_phase_n;
    logic step;
    logic [LAMPS-1:0] fill, hz_all, l_seq, r_seq;

    tbird_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .step (step)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            step_cnt <= '0;
            hz_phase <= 1'b0;
        end else begin
            state    <= state_n;
            step_cnt <= step_cnt_n;
            hz_phase <= hz_phase_n;
        end
    end

    always_comb begin
        state_n    = state;
        step_cnt_n = step_cnt;
        hz_phase_n = hz_phase;
        if (step) begin
            case (state)
                IDLE: begin
                    if (bus.hazard) begin
                        state_n    = HAZARD;
                        hz_phase_n = 1'b1;
                    end else if (bus.left ^ bus.right) begin
                        state_n    = bus.left ? LEFT : RIGHT;
                        step_cnt_n = SW'(1);
                    end
                end
                LEFT, RIGHT: begin
                    if (bus.hazard) begin
                        state_n    = HAZARD;
                        hz_phase_n = 1'b1;
                        step_cnt_n = '0;
                    end else if (step_cnt < SW'(LAMPS)) begin
                        step_cnt_n = step_cnt + SW'(1);
                    end else begin
                        state_n    = IDLE;
                        step_cnt_n = '0;
                    end
                end
                default: begin
                    state_n    = bus.hazard ? HAZARD : IDLE;
                    hz_phase_n = bus.hazard && !hz_phase;
                end
            endcase
        end
    end

    assign fill   = LAMPS'(thermo(int'(step_cnt)));
    assign hz_all = {LAMPS{hz_phase}};
    assign l_seq  = state == LEFT ? fill : state == HAZARD ? hz_all : '0;
    assign r_seq  = state == RIGHT ? fill : state == HAZARD ? hz_all : '0;

`ifdef TBIRD_BRAKE_EN
    // Brake lights every lamp on the side that is not sequencing; hazard wins.
    assign bus.l_lamps = bus.brake && (state == IDLE || state == RIGHT) ? '1 : l_seq;
    assign bus.r_lamps = bus.brake && (state == IDLE || state == LEFT) ? '1 : r_seq;
`else
    assign bus.l_lamps = l_seq;
    assign bus.r_lamps = r_seq;
`endif
    assign bus.step = step;

endmodule
